// File: rtl/reg_wb_arbiter_if.sv
// Writeback request/response bundle between two requesters and the register-file port.
// The slave modport is the arbiter; the master modport is the requester/regfile side.
interface reg_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              busy;
  logic              gnt_b;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, RegWrite, A3, WD3, busy, gnt_b
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, RegWrite, A3, WD3, busy, gnt_b
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter: a small FIFO per requester, round-robin
// grant of one head per cycle, registered write port; address-0 writes are dropped.
module reg_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  reg_wb_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Index 0 is requester A, index 1 is requester B.
  logic [ADDR_W-1:0] addr_mem_q [2][DEPTH];
  logic [DATA_W-1:0] data_mem_q [2][DEPTH];
  logic [PtrW-1:0]   rd_ptr_q   [2];
  logic [PtrW-1:0]   wr_ptr_q   [2];
  logic [CntW-1:0]   cnt_q      [2];

  logic              en_q;
  logic              last_b_q;

  logic              in_valid   [2];
  logic [ADDR_W-1:0] in_addr    [2];
  logic [DATA_W-1:0] in_data    [2];
  logic              ready      [2];
  logic              has        [2];
  logic              push       [2];
  logic              pop        [2];

  logic              grant;
  logic              sel_b;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic              reg_write_d, reg_write_q;
  logic              gnt_b_d, gnt_b_q;
  logic [ADDR_W-1:0] a3_d, a3_q;
  logic [DATA_W-1:0] wd3_d, wd3_q;

  always_comb begin
    in_valid[0] = bus.a_valid;
    in_addr[0]  = bus.a_addr;
    in_data[0]  = bus.a_data;
    in_valid[1] = bus.b_valid;
    in_addr[1]  = bus.b_addr;
    in_data[1]  = bus.b_data;
    // en_q keeps ready low through reset and until the first clock edge after it.
    for (int r = 0; r < 2; r++) begin
      ready[r] = en_q && (cnt_q[r] < CntFull);
      has[r]   = (cnt_q[r] != '0);
      push[r]  = in_valid[r] && ready[r];
    end
    // On a tie the requester not granted most recently wins.
    sel_b     = has[1] && (!has[0] || !last_b_q);
    grant     = has[0] || has[1];
    pop[0]    = has[0] && !sel_b;
    pop[1]    = sel_b;
    head_addr = addr_mem_q[sel_b][rd_ptr_q[sel_b]];
    head_data = data_mem_q[sel_b][rd_ptr_q[sel_b]];
  end

  always_comb begin
    reg_write_d = 1'b0;
    gnt_b_d     = gnt_b_q;
    a3_d        = a3_q;
    wd3_d       = wd3_q;
    if (grant) begin
      reg_write_d = (head_addr != '0);
      gnt_b_d     = sel_b;
      a3_d        = head_addr;
      wd3_d       = head_data;
    end
  end

  // Storage needs no reset: an entry is only read while its count is non-zero.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        addr_mem_q[r][wr_ptr_q[r]] <= in_addr[r];
        data_mem_q[r][wr_ptr_q[r]] <= in_data[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q        <= 1'b0;
      last_b_q    <= 1'b1;
      reg_write_q <= 1'b0;
      gnt_b_q     <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
      for (int r = 0; r < 2; r++) begin
        rd_ptr_q[r] <= '0;
        wr_ptr_q[r] <= '0;
        cnt_q[r]    <= '0;
      end
    end else begin
      en_q        <= 1'b1;
      reg_write_q <= reg_write_d;
      gnt_b_q     <= gnt_b_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      if (grant) begin
        last_b_q <= sel_b;
      end
      for (int r = 0; r < 2; r++) begin
        if (push[r]) begin
          wr_ptr_q[r] <= wr_ptr_q[r] + PtrW'(1);
        end
        if (pop[r]) begin
          rd_ptr_q[r] <= rd_ptr_q[r] + PtrW'(1);
        end
        if (push[r] && !pop[r]) begin
          cnt_q[r] <= cnt_q[r] + CntW'(1);
        end else if (!push[r] && pop[r]) begin
          cnt_q[r] <= cnt_q[r] - CntW'(1);
        end
      end
    end
  end

  assign bus.a_ready  = ready[0];
  assign bus.b_ready  = ready[1];
  assign bus.RegWrite = reg_write_q;
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd3_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.busy     = has[0] || has[1] || reg_write_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed, table-driven bench for reg_wb_arbiter (DEPTH=2): each vector drives inputs for
// one cycle and checks every output just after the following rising edge.
module tb_reg_wb_arbiter;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        rw;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        gb;
    logic        bs;
  } vec_t;

  vec_t vecs[$];

  reg_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic ar, input logic br, input logic rw,
                              input logic [4:0] a3, input logic [31:0] wd,
                              input logic gb, input logic bs);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ar = ar; v.br = br; v.rw = rw; v.a3 = a3; v.wd = wd; v.gb = gb; v.bs = bs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    bus.a_valid = v.av;
    bus.a_addr  = v.aa;
    bus.a_data  = v.ad;
    bus.b_valid = v.bv;
    bus.b_addr  = v.ba;
    bus.b_data  = v.bd;
    step();
    chk({tag, ".a_ready"},  32'(bus.a_ready),  32'(v.ar));
    chk({tag, ".b_ready"},  32'(bus.b_ready),  32'(v.br));
    chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(v.rw));
    chk({tag, ".A3"},       32'(bus.A3),       32'(v.a3));
    chk({tag, ".WD3"},      bus.WD3,           v.wd);
    chk({tag, ".gnt_b"},    32'(bus.gnt_b),    32'(v.gb));
    chk({tag, ".busy"},     32'(bus.busy),     32'(v.bs));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'd0);
    chk({tag, ".A3"},       32'(bus.A3),       32'd0);
    chk({tag, ".WD3"},      bus.WD3,           32'd0);
    chk({tag, ".gnt_b"},    32'(bus.gnt_b),    32'd0);
    chk({tag, ".a_ready"},  32'(bus.a_ready),  32'd0);
    chk({tag, ".b_ready"},  32'(bus.b_ready),  32'd0);
    chk({tag, ".busy"},     32'(bus.busy),     32'd0);
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_addr  = '0;
    bus.b_addr  = '0;
    bus.a_data  = '0;
    bus.b_data  = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // Fields: A in (v,addr,data), B in (v,addr,data), exp a_ready, b_ready, RegWrite, A3,
    // WD3, gnt_b, busy. Expectations hold just after the edge the inputs were applied to.
    // Contention: A r1,r2 vs B r5,r6, tie goes to A first out of reset.
    vecs.push_back(mk(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd5, 32'h5555_5555,
                      1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd6, 32'h6666_6666,
                      1'b1, 1'b0, 1'b1, 5'd1, 32'h1111_1111, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd5, 32'h5555_5555, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd6, 32'h6666_6666, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd6, 32'h6666_6666, 1'b1, 1'b0));
    // Single write, two-edge latency.
    vecs.push_back(mk(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd6, 32'h6666_6666, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd3, 32'h1234_5678, 1'b0, 1'b0));
    // B write, then A address-0 write, then a tie that must go to B.
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777_7777,
                      1'b1, 1'b1, 1'b0, 5'd3, 32'h1234_5678, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd7, 32'h7777_7777, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd7, 32'h7777_7777, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd8, 32'h8888_8888,
                      1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd8, 32'h8888_8888, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd4, 32'h4444_4444, 1'b0, 1'b0));
    // A pushes every cycle while being drained every cycle.
    vecs.push_back(mk(1'b1, 5'd9, 32'h0000_0009, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd4, 32'h4444_4444, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 5'd10, 32'h0000_000A, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0009, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 5'd11, 32'h0000_000B, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_000A, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 5'd12, 32'h0000_000C, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_000B, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_000C, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_000C, 1'b0, 1'b0));

    // Power-on reset.
    reset = 1'b1;
    idle_inputs();
    #12;
    chk_reset_outputs("por");
    step();
    reset = 1'b0;
    #1;
    chk("por_release.a_ready", 32'(bus.a_ready), 32'd0);
    step();
    chk("first_edge.a_ready", 32'(bus.a_ready), 32'd1);
    chk("first_edge.b_ready", 32'(bus.b_ready), 32'd1);
    chk("first_edge.busy",    32'(bus.busy),    32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-stream: three entries queued plus a pending output slot.
    apply(mk(1'b1, 5'd13, 32'h0000_00D0, 1'b1, 5'd14, 32'h0000_00E0,
             1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_000C, 1'b0, 1'b1), "mid0");
    apply(mk(1'b1, 5'd15, 32'h0000_00F0, 1'b1, 5'd16, 32'h0000_0100,
             1'b0, 1'b1, 1'b1, 5'd14, 32'h0000_00E0, 1'b1, 1'b1), "mid1");
    #2;
    reset = 1'b1;
    idle_inputs();
    #1;
    chk_reset_outputs("async_rst");
    step();
    step();
    chk_reset_outputs("held_rst");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst%0d.RegWrite", i), 32'(bus.RegWrite), 32'd0);
      chk($sformatf("post_rst%0d.busy", i),     32'(bus.busy),     32'd0);
      chk($sformatf("post_rst%0d.a_ready", i),  32'(bus.a_ready),  32'd1);
      chk($sformatf("post_rst%0d.b_ready", i),  32'(bus.b_ready),  32'd1);
    end

    // Backpressure on B: B's third value is refused once, held, then accepted.
    apply(mk(1'b1, 5'd16, 32'hA000_0000, 1'b1, 5'd20, 32'hB000_0000,
             1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1), "bp0");
    apply(mk(1'b1, 5'd17, 32'hA000_0001, 1'b1, 5'd21, 32'hB000_0001,
             1'b1, 1'b0, 1'b1, 5'd16, 32'hA000_0000, 1'b0, 1'b1), "bp1");
    apply(mk(1'b1, 5'd18, 32'hA000_0002, 1'b1, 5'd22, 32'hB000_0002,
             1'b0, 1'b1, 1'b1, 5'd20, 32'hB000_0000, 1'b1, 1'b1), "bp2");
    apply(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hB000_0002,
             1'b1, 1'b0, 1'b1, 5'd17, 32'hA000_0001, 1'b0, 1'b1), "bp3");
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b1, 1'b1, 1'b1, 5'd21, 32'hB000_0001, 1'b1, 1'b1), "bp4");
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b1, 1'b1, 1'b1, 5'd18, 32'hA000_0002, 1'b0, 1'b1), "bp5");
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b1, 1'b1, 1'b1, 5'd22, 32'hB000_0002, 1'b1, 1'b1), "bp6");
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b1, 1'b1, 1'b0, 5'd22, 32'hB000_0002, 1'b1, 1'b0), "bp7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
